mux4_rr_sched: RTL and testbench

- Round-robin scheduler that shares the 4:1 select mux (inputs a, b, c, d; selects s1:s0) among four requesters.
- Arbitrates on the requests, registers a one-hot grant, and drives s0/s1 so the granted requester's input reaches the mux output.
- Bounds each tenure with a hold counter so no requester can starve the others.
- Sits directly in front of the mux; s0/s1 connect straight to its select pins.

---
 rtl/mux4_rr_sched_if.sv | 14 +
 rtl/mux4_rr_sched.sv | 132 +++++++++++++
 tb/tb_mux4_rr_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mux4_rr_sched_if.sv
// Request/grant bundle between the requesters and the 4:1 mux select scheduler.
interface mux4_rr_sched_if #(
  parameter int CNT_W = 4
);
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic             s0;
  logic             s1;
  logic             busy;
  logic [CNT_W-1:0] hold_cnt;

  modport master (output req, input gnt, s0, s1, busy, hold_cnt);
  modport slave  (input req, output gnt, s0, s1, busy, hold_cnt);
endinterface

// File: rtl/mux4_rr_sched.sv
// Round-robin owner of the 4:1 mux select with per-tenure hold limit.
// Optional macro MUX4_RR_SCHED_PRIO0_EN makes req[0] a preempting strict-priority requester.
module mux4_rr_sched #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mux4_rr_sched_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic             release_w;
  logic             grant_w;
  logic [1:0]       pick_w;
`ifdef MUX4_RR_SCHED_PRIO0_EN
  logic             skip0_q, skip0_d;
`endif

  // First set bit searching after+1, after+2, ... wrapping back onto after itself.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] after);
    logic [1:0] idx;
    logic [1:0] res;
    logic       done;
    res  = after;
    done = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = after + 2'(k);
      if (!done && r[idx]) begin
        res  = idx;
        done = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    release_w = 1'b0;
    grant_w   = 1'b0;
    pick_w    = rr_pick(bus.req, last_q);
`ifdef MUX4_RR_SCHED_PRIO0_EN
    skip0_d   = skip0_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MUX4_RR_SCHED_PRIO0_EN
        if (bus.req[0]) pick_w = 2'd0;
`endif
        grant_w = |bus.req;
      end
      GRANT: begin
        release_w = !bus.req[sel_q] || (cnt_q == HOLD_LAST);
        pick_w    = rr_pick(bus.req, sel_q);
`ifdef MUX4_RR_SCHED_PRIO0_EN
        if (sel_q != 2'd0 && bus.req[0] && !skip0_q) release_w = 1'b1;
`endif
        if (!release_w) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (|bus.req) begin
          grant_w = 1'b1;
`ifdef MUX4_RR_SCHED_PRIO0_EN
          // An expiring requester 0 yields one round-robin tenure before it may preempt again.
          if (sel_q == 2'd0 && cnt_q == HOLD_LAST && |bus.req[3:1]) begin
            pick_w  = rr_pick({bus.req[3:1], 1'b0}, 2'd0);
            skip0_d = 1'b1;
          end else begin
            if (bus.req[0]) pick_w = 2'd0;
            skip0_d = 1'b0;
          end
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          cnt_d   = '0;
`ifdef MUX4_RR_SCHED_PRIO0_EN
          skip0_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_w) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << pick_w;
      sel_d   = pick_w;
      cnt_d   = '0;
      last_d  = pick_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      last_q  <= 2'd3;
`ifdef MUX4_RR_SCHED_PRIO0_EN
      skip0_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
`ifdef MUX4_RR_SCHED_PRIO0_EN
      skip0_q <= skip0_d;
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.s0       = sel_q[0];
  assign bus.s1       = sel_q[1];
  assign bus.busy     = (state_q == GRANT);
  assign bus.hold_cnt = cnt_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Scoreboard bench for mux4_rr_sched: driver pushes expected post-edge outputs, monitor pops and compares.
module tb_mux4_rr_sched;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mux4_rr_sched_if #(.CNT_W(CNT_W)) bus ();

  mux4_rr_sched #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    int         sel;
    logic       busy;
    int         cnt;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   drv_done = 1'b0;
  int   cyc_n = 0;

  // Reference model state: who owns the mux and for how long.
  bit m_busy;
  int m_cur, m_cnt, m_last, m_sel;

  function automatic int next_from(logic [3:0] r, int after);
    for (int k = 1; k <= 4; k++) begin
      if (r[(after + k) % 4]) return (after + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(logic rn, logic [3:0] r);
    int n;
    if (!rn) begin
      m_busy = 0; m_cur = 0; m_cnt = 0; m_last = 3; m_sel = 0;
    end else if (!m_busy) begin
      n = next_from(r, m_last);
      if (n >= 0) begin m_busy = 1; m_cur = n; m_sel = n; m_cnt = 0; m_last = n; end
    end else if (r[m_cur] && m_cnt < MAX_HOLD - 1) begin
      m_cnt++;
    end else begin
      n = next_from(r, m_cur);
      if (n >= 0) begin m_cur = n; m_sel = n; m_cnt = 0; m_last = n; end
      else begin m_busy = 0; m_cnt = 0; end
    end
  endtask

  task automatic drive(logic rn, logic [3:0] r);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n   = rn;
    bus.req = r;
    cyc_n++;
    model_step(rn, r);
    e.gnt  = m_busy ? (4'b0001 << m_cur) : 4'b0000;
    e.sel  = m_sel;
    e.busy = m_busy;
    e.cnt  = m_cnt;
    e.cyc  = cyc_n;
    q.push_back(e);
  endtask

  task automatic hold(logic rn, logic [3:0] r, int n);
    for (int i = 0; i < n; i++) drive(rn, r);
  endtask

  task automatic chk(string name, int act, int req_v, int cyc);
    checks++;
    if (act != req_v) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req_v);
    end
  endtask

  // Driver
  initial begin
    bus.req = 4'b0000;
    hold(1'b0, 4'b0000, 2);
    hold(1'b1, 4'b0000, 5);
    hold(1'b1, 4'b1111, 40);
    hold(1'b1, 4'b0000, 3);
    hold(1'b1, 4'b0100, 20);
    hold(1'b1, 4'b0000, 2);
    hold(1'b1, 4'b0010, 3);
    hold(1'b1, 4'b0000, 4);
    hold(1'b1, 4'b1000, 6);
    drive(1'b0, 4'b1111);
    hold(1'b1, 4'b1111, 3);
    hold(1'b1, 4'b0000, 2);
    drive(1'b1, 4'b0001);
    hold(1'b1, 4'b0000, 3);
    for (int i = 0; i < 120; i++) begin
      logic [3:0] r;
      int         len;
      r   = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 40) == 0) drive(1'b0, r);
      else hold(1'b1, r, len);
    end
    drv_done = 1'b1;
  end

  // Monitor
  initial begin
    int waited;
    exp_t e;
    waited = 0;
    while (!(drv_done && q.size() == 0)) begin
      @(negedge clk);
      waited++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", int'(bus.gnt), int'(e.gnt), e.cyc);
        chk("sel", int'({bus.s1, bus.s0}), e.sel, e.cyc);
        chk("busy", int'(bus.busy), int'(e.busy), e.cyc);
        chk("hold_cnt", int'(bus.hold_cnt), e.cnt, e.cyc);
        chk("gnt_onehot", int'($countones(bus.gnt) <= 1), 1, e.cyc);
        chk("hold_cnt_max", int'(int'(bus.hold_cnt) <= MAX_HOLD - 1), 1, e.cyc);
      end
      if (waited > 20000) begin
        checks++;
        failures++;
        $display("FAIL timeout cyc=%0d actual=%0d required=%0d", waited, q.size(), 0);
        break;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
